lif_neuron_bank: RTL

Four-lane leaky integrate-and-fire neuron bank sitting directly downstream of the 2x2 Strassen multiplier. It consumes the multiplier's packed 4-lane product word (one lane per output element C[0..3]) as synaptic current. It accumulates any number of product beats per timestep. At each timestep boundary it applies leak, integrates, thresholds, emits a spike vector and enforces per-lane refractory periods.

---
 rtl/snn_pkg.sv | 55 +++++
 rtl/lif_neuron_bank_if.sv | 29 ++
 rtl/lif_lane.sv | 75 +++++++
 rtl/lif_neuron_bank.sv | 115 +++++++++++
 4 files changed

// File: rtl/snn_pkg.sv
// Shared types and helpers for the LIF neuron bank: lane count, FSM states,
// saturating arithmetic and packed-lane extraction.
// No ports; imported by lif_lane, lif_neuron_bank_if and lif_neuron_bank.
package snn_pkg;

  localparam int NUM_LANES = 4;
  // Working width for helper arithmetic; wide enough for any DATAWIDTH <= 62
  // without intermediate overflow.
  localparam int MAXW = 64;

  typedef enum logic [1:0] {
    ACCUM  = 2'd0,
    UPDATE = 2'd1,
    FIRE   = 2'd2
  } lif_state_e;

  // Adds two sign-extended operands and clamps to the signed range of 'width'
  // bits. The result is returned sign-extended to MAXW bits.
  function automatic logic signed [MAXW-1:0] sat_add(
    input logic signed [MAXW-1:0] a,
    input logic signed [MAXW-1:0] b,
    input int                     width
  );
    logic signed [MAXW-1:0] sum;
    logic signed [MAXW-1:0] hi;
    logic signed [MAXW-1:0] lo;
    sum = a + b;
    hi  = (MAXW'(1) <<< (width - 1)) - MAXW'(1);
    lo  = -(MAXW'(1) <<< (width - 1));
    if (sum > hi) begin
      sat_add = hi;
    end else if (sum < lo) begin
      sat_add = lo;
    end else begin
      sat_add = sum;
    end
  endfunction

  // Pulls lane k (each 'width' bits) out of a zero-padded packed bus and
  // sign-extends it to MAXW bits.
  function automatic logic signed [MAXW-1:0] lane_extract(
    input logic [NUM_LANES*MAXW-1:0] bus,
    input int                        k,
    input int                        width
  );
    logic [NUM_LANES*MAXW-1:0] sh;
    logic signed [MAXW-1:0]    r;
    sh = bus >> (k * width);
    r  = sh[MAXW-1:0];
    r  = r <<< (MAXW - width);
    r  = r >>> (MAXW - width);
    lane_extract = r;
  endfunction

endpackage

// File: rtl/lif_neuron_bank_if.sv
// Handshake/data bundle between the product source and the neuron bank.
// master: upstream side (drives c_in/c_valid/step_end, sees ready and results)
// slave : neuron bank side (consumes beats, drives in_ready, spikes, v_out, step_cnt)
interface lif_neuron_bank_if #(
  parameter int DATAWIDTH = 32,
  parameter int STEPW     = 16
);
  import snn_pkg::*;

  logic [NUM_LANES*DATAWIDTH-1:0] c_in;
  logic                           c_valid;
  logic                           step_end;
  logic                           in_ready;
  logic [NUM_LANES-1:0]           spike_out;
  logic                           spike_valid;
  logic [NUM_LANES*DATAWIDTH-1:0] v_out;
  logic [STEPW-1:0]               step_cnt;

  modport master (
    output c_in, c_valid, step_end,
    input  in_ready, spike_out, spike_valid, v_out, step_cnt
  );

  modport slave (
    input  c_in, c_valid, step_end,
    output in_ready, spike_out, spike_valid, v_out, step_cnt
  );

endinterface

// File: rtl/lif_lane.sv
// One LIF neuron: owns accumulator, membrane potential and refractory counter.
// Ports: clk/rst, do_accum/do_update/do_fire strobes (mutually exclusive),
// lane_in current, v registered potential, fire = v at/above threshold.
module lif_lane
  import snn_pkg::*;
#(
  parameter int DATAWIDTH     = 32,
  parameter int THRESHOLD     = 100,
  parameter int LEAK_SHIFT    = 4,
  parameter int REFRAC_CYCLES = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        do_accum,
  input  logic                        do_update,
  input  logic                        do_fire,
  input  logic signed [DATAWIDTH-1:0] lane_in,
  output logic signed [DATAWIDTH-1:0] v,
  output logic                        fire
);

  localparam int RW = (REFRAC_CYCLES < 1) ? 1 : $clog2(REFRAC_CYCLES + 1);
  localparam logic signed [DATAWIDTH-1:0] THR = DATAWIDTH'(THRESHOLD);

  logic signed [DATAWIDTH-1:0] acc_q, acc_d;
  logic signed [DATAWIDTH-1:0] v_q, v_d;
  logic [RW-1:0]               refr_q, refr_d;
  logic signed [DATAWIDTH-1:0] mem_sat;

  assign v    = v_q;
  assign fire = (v_q >= THR);

  always_comb begin
    acc_d   = acc_q;
    v_d     = v_q;
    refr_d  = refr_q;
    // Leak and integrate in one clamped sum; v is never negative so the
    // leak term never increases v.
    mem_sat = DATAWIDTH'(sat_add(MAXW'(v_q) - MAXW'(v_q >>> LEAK_SHIFT),
                                 MAXW'(acc_q), DATAWIDTH));

    if (do_accum) begin
      acc_d = DATAWIDTH'(sat_add(MAXW'(acc_q), MAXW'(lane_in), DATAWIDTH));
    end

    if (do_update) begin
      acc_d = '0;
      if (refr_q != '0) begin
        // Refractory: this step's input is dropped, neuron stays silent.
        refr_d = refr_q - RW'(1);
        v_d    = '0;
      end else begin
        v_d = (mem_sat < 0) ? '0 : mem_sat;
      end
    end

    if (do_fire && fire) begin
      v_d    = '0;
      refr_d = RW'(REFRAC_CYCLES);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q  <= '0;
      v_q    <= '0;
      refr_q <= '0;
    end else begin
      acc_q  <= acc_d;
      v_q    <= v_d;
      refr_q <= refr_d;
    end
  end

endmodule

// File: rtl/lif_neuron_bank.sv
// Four-lane leaky integrate-and-fire bank fed by packed multiplier products.
// Latency: beat folds into acc at accept edge; spikes 2 edges after step_end.
// Backpressure: in_ready low during UPDATE/FIRE; beats/step_end then ignored.
// Ports: clk, rst (sync, active-high), bus (slave modport of lif_neuron_bank_if).
module lif_neuron_bank
  import snn_pkg::*;
#(
  parameter int DATAWIDTH     = 32,
  parameter int THRESHOLD     = 100,
  parameter int LEAK_SHIFT    = 4,
  parameter int REFRAC_CYCLES = 2,
  parameter int STEPW         = 16
) (
  input  logic               clk,
  input  logic               rst,
  lif_neuron_bank_if.slave   bus
);

  lif_state_e state_q, state_d;
  logic       in_ready_c;
  logic       do_accum, do_update, do_fire;

  logic [NUM_LANES-1:0] spike_q, spike_d;
  logic                 spike_valid_q, spike_valid_d;
  logic [STEPW-1:0]     step_cnt_q, step_cnt_d;

  logic [NUM_LANES*MAXW-1:0]      c_in_wide;
  logic signed [DATAWIDTH-1:0]    lane_in [NUM_LANES];
  logic signed [DATAWIDTH-1:0]    v_lane  [NUM_LANES];
  logic                           fire_lane [NUM_LANES];
  logic [NUM_LANES-1:0]           fire_vec;
  logic [NUM_LANES*DATAWIDTH-1:0] v_out_c;

  assign c_in_wide = (NUM_LANES*MAXW)'(bus.c_in);

  always_comb begin
    state_d    = state_q;
    in_ready_c = 1'b0;
    do_accum   = 1'b0;
    do_update  = 1'b0;
    do_fire    = 1'b0;
    case (state_q)
      ACCUM: begin
        in_ready_c = 1'b1;
        do_accum   = bus.c_valid;
        if (bus.step_end) state_d = UPDATE;
      end
      UPDATE: begin
        do_update = 1'b1;
        state_d   = FIRE;
      end
      FIRE: begin
        do_fire = 1'b1;
        state_d = ACCUM;
      end
      default: state_d = ACCUM;
    endcase
  end

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    assign lane_in[k] = DATAWIDTH'(lane_extract(c_in_wide, k, DATAWIDTH));

    lif_lane #(
      .DATAWIDTH    (DATAWIDTH),
      .THRESHOLD    (THRESHOLD),
      .LEAK_SHIFT   (LEAK_SHIFT),
      .REFRAC_CYCLES(REFRAC_CYCLES)
    ) u_lane (
      .clk      (clk),
      .rst      (rst),
      .do_accum (do_accum),
      .do_update(do_update),
      .do_fire  (do_fire),
      .lane_in  (lane_in[k]),
      .v        (v_lane[k]),
      .fire     (fire_lane[k])
    );
  end

  always_comb begin
    v_out_c  = '0;
    fire_vec = '0;
    for (int k = 0; k < NUM_LANES; k++) begin
      v_out_c[k*DATAWIDTH +: DATAWIDTH] = v_lane[k];
      fire_vec[k]                       = fire_lane[k];
    end
  end

  always_comb begin
    spike_d       = do_fire ? fire_vec : spike_q;
    spike_valid_d = do_fire;
    step_cnt_d    = step_cnt_q + {{(STEPW-1){1'b0}}, do_fire};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ACCUM;
      spike_q       <= '0;
      spike_valid_q <= 1'b0;
      step_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      spike_q       <= spike_d;
      spike_valid_q <= spike_valid_d;
      step_cnt_q    <= step_cnt_d;
    end
  end

  assign bus.in_ready    = in_ready_c;
  assign bus.spike_out   = spike_q;
  assign bus.spike_valid = spike_valid_q;
  assign bus.v_out       = v_out_c;
  assign bus.step_cnt    = step_cnt_q;

endmodule
